// File: rtl/clint.sv
// Core-local trap sequencer: detects ECALL/EBREAK/MRET/interrupts in idle, writes
// mepc/mcause/mstatus over the CSR port, then strobes a PC redirect.
module clint #(
  parameter logic [11:0] CSR_MEPC    = 12'h341,
  parameter logic [11:0] CSR_MCAUSE  = 12'h342,
  parameter logic [11:0] CSR_MSTATUS = 12'h300,
  parameter logic [31:0] CAUSE_TIMER = 32'h8000_0007,
  parameter logic [31:0] CAUSE_EXT   = 32'h8000_000B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [7:0]  int_flag_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        hold_flag_o,
  output logic        we_o,
  output logic [11:0] waddr_o,
  output logic [31:0] data_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_MEPC        = 3'd1,
    S_MCAUSE      = 3'd2,
    S_MSTATUS     = 3'd3,
    S_ASSERT      = 3'd4,
    S_MRET        = 3'd5,
    S_MRET_ASSERT = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        we_q, we_d;
  logic [11:0] waddr_q, waddr_d;
  logic [31:0] data_q, data_d;
  logic        int_assert_q, int_assert_d;
  logic [31:0] int_addr_q, int_addr_d;

  logic ev_sync, ev_async, ev_mret;

  always_comb begin
    ev_sync  = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
    ev_async = (int_flag_i != '0) && csr_mstatus_i[3];
    ev_mret  = (inst_i == INST_MRET);
  end

  always_comb begin
    hold_flag_o = (state_q != S_IDLE) || ev_sync || ev_async || ev_mret;
  end

  // Outputs are registered from the next state so they line up with the state occupied.
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    epc_d        = epc_q;
    we_d         = 1'b0;
    waddr_d      = '0;
    data_d       = '0;
    int_assert_d = 1'b0;
    int_addr_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (ev_sync) begin
          cause_d = (inst_i == INST_EBREAK) ? 32'd3 : 32'd11;
          epc_d   = inst_addr_i;
          state_d = S_MEPC;
        end else if (ev_async) begin
          cause_d = int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
          epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
          state_d = S_MEPC;
        end else if (ev_mret) begin
          state_d = S_MRET;
        end
      end
      S_MEPC:        state_d = S_MCAUSE;
      S_MCAUSE:      state_d = S_MSTATUS;
      S_MSTATUS:     state_d = S_ASSERT;
      S_ASSERT:      state_d = S_IDLE;
      S_MRET:        state_d = S_MRET_ASSERT;
      S_MRET_ASSERT: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase

    case (state_d)
      S_MEPC: begin
        we_d    = 1'b1;
        waddr_d = CSR_MEPC;
        data_d  = epc_d;
      end
      S_MCAUSE: begin
        we_d    = 1'b1;
        waddr_d = CSR_MCAUSE;
        data_d  = cause_d;
      end
      S_MSTATUS: begin
        we_d      = 1'b1;
        waddr_d   = CSR_MSTATUS;
        data_d    = csr_mstatus_i;
        data_d[7] = csr_mstatus_i[3];
        data_d[3] = 1'b0;
      end
      S_ASSERT: begin
        int_assert_d = 1'b1;
        int_addr_d   = csr_mtvec_i;
      end
      S_MRET: begin
        we_d      = 1'b1;
        waddr_d   = CSR_MSTATUS;
        data_d    = csr_mstatus_i;
        data_d[3] = csr_mstatus_i[7];
        data_d[7] = 1'b1;
      end
      S_MRET_ASSERT: begin
        int_assert_d = 1'b1;
        int_addr_d   = csr_mepc_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cause_q      <= '0;
      epc_q        <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      data_q       <= '0;
      int_assert_q <= 1'b0;
      int_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      epc_q        <= epc_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      data_q       <= data_d;
      int_assert_q <= int_assert_d;
      int_addr_q   <= int_addr_d;
    end
  end

  always_comb begin
    we_o         = we_q;
    waddr_o      = waddr_q;
    data_o       = data_q;
    int_assert_o = int_assert_q;
    int_addr_o   = int_addr_q;
  end

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: stimulus pushes expected CSR writes / redirects with
// their cycle stamps; a monitor pops and compares whenever the DUT presents one.
module tb_clint;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i;
  logic [7:0]  int_flag_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        hold_flag_o, we_o, int_assert_o;
  logic [11:0] waddr_o;
  logic [31:0] data_o, int_addr_o;

  localparam logic [31:0] NOP = 32'h0000_0013;

  clint dut (
    .clk          (clk),
    .rst          (rst),
    .inst_i       (inst_i),
    .inst_addr_i  (inst_addr_i),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .int_flag_i   (int_flag_i),
    .csr_mtvec_i  (csr_mtvec_i),
    .csr_mepc_i   (csr_mepc_i),
    .csr_mstatus_i(csr_mstatus_i),
    .hold_flag_o  (hold_flag_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .data_o       (data_o),
    .int_assert_o (int_assert_o),
    .int_addr_o   (int_addr_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    bit          is_wr;
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic exp_w(input int at, input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    e.at = at; e.is_wr = 1'b1; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_j(input int at, input logic [31:0] target);
    exp_t e;
    e.at = at; e.is_wr = 1'b0; e.addr = '0; e.data = target;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every presented write/redirect against the scoreboard.
  always @(negedge clk) begin
    if (we_o || int_assert_o) begin
      chk(hold_flag_o == 1'b1, "hold_busy", {63'd0, hold_flag_o}, 64'd1);
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_out", {19'd0, we_o, waddr_o, data_o}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(cyc == e.at, "sb_cycle", 64'(cyc), 64'(e.at));
        if (e.is_wr)
          chk(we_o && !int_assert_o && waddr_o == e.addr && data_o == e.data, "sb_csr_write",
              {19'd0, we_o, waddr_o, data_o}, {19'd0, 1'b1, e.addr, e.data});
        else
          chk(int_assert_o && !we_o && int_addr_o == e.data, "sb_redirect",
              {31'd0, int_assert_o, int_addr_o}, {31'd0, 1'b1, e.data});
      end
    end else if (rst) begin
      chk(waddr_o == '0 && data_o == '0 && int_addr_o == '0, "idle_zero",
          {20'd0, waddr_o, data_o} | {32'd0, int_addr_o}, 64'd0);
    end
  end

  task automatic fire(input logic [31:0] inst, input logic [31:0] addr, input logic [7:0] irq,
                      input logic jf, input logic [31:0] ja, input logic [31:0] mst, output int n);
    @(negedge clk); #2;
    inst_i = inst; inst_addr_i = addr; int_flag_i = irq;
    jump_flag_i = jf; jump_addr_i = ja; csr_mstatus_i = mst;
    #1;
    chk(hold_flag_o == 1'b1, "hold_detect", {63'd0, hold_flag_o}, 64'd1);
    n = cyc;
  endtask

  task automatic settle(input bit clear_irq);
    @(negedge clk); #2;
    inst_i = NOP; jump_flag_i = 1'b0;
    if (clear_irq) int_flag_i = '0;
  endtask

  task automatic finish_seq(input int cycles, input string name);
    repeat (cycles) @(negedge clk);
    #2;
    chk(hold_flag_o == 1'b0, {name, "_hold_released"}, {63'd0, hold_flag_o}, 64'd0);
    chk(exp_q.size() == 0, {name, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  int n;

  initial begin
    rst = 1'b0;
    inst_i = NOP; inst_addr_i = '0; jump_flag_i = 1'b0; jump_addr_i = '0;
    int_flag_i = 8'hFF; csr_mtvec_i = 32'h200; csr_mepc_i = '0; csr_mstatus_i = '0;
    #3;
    chk({hold_flag_o, we_o, int_assert_o, waddr_o, data_o, int_addr_o} == '0, "reset_outputs",
        {hold_flag_o, we_o, int_assert_o, waddr_o, data_o}, 64'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk(hold_flag_o == 1'b0 && !we_o && !int_assert_o, "post_reset_masked",
        {61'd0, hold_flag_o, we_o, int_assert_o}, 64'd0);
    int_flag_i = '0;

    // ECALL
    fire(32'h0000_0073, 32'h100, 8'h00, 1'b0, 32'h0, 32'h8, n);
    exp_w(n + 1, 12'h341, 32'h100);
    exp_w(n + 2, 12'h342, 32'h0000_000B);
    exp_w(n + 3, 12'h300, 32'h0000_0080);
    exp_j(n + 4, 32'h200);
    settle(1'b1);
    finish_seq(4, "ecall");

    // Timer interrupt while ex redirects; line drops mid-sequence
    fire(NOP, 32'h120, 8'h01, 1'b1, 32'h400, 32'h8, n);
    exp_w(n + 1, 12'h341, 32'h400);
    exp_w(n + 2, 12'h342, 32'h8000_0007);
    exp_w(n + 3, 12'h300, 32'h0000_0080);
    exp_j(n + 4, 32'h200);
    settle(1'b1);
    finish_seq(4, "timer");

    // MRET
    csr_mepc_i = 32'h104;
    fire(32'h3020_0073, 32'h130, 8'h00, 1'b0, 32'h0, 32'h80, n);
    exp_w(n + 1, 12'h300, 32'h0000_0088);
    exp_j(n + 2, 32'h104);
    settle(1'b1);
    finish_seq(2, "mret");

    // EBREAK beats a pending external interrupt
    fire(32'h0010_0073, 32'h140, 8'h02, 1'b0, 32'h0, 32'h8, n);
    exp_w(n + 1, 12'h341, 32'h140);
    exp_w(n + 2, 12'h342, 32'h0000_0003);
    exp_w(n + 3, 12'h300, 32'h0000_0080);
    exp_j(n + 4, 32'h200);
    settle(1'b0);
    repeat (3) @(negedge clk);
    #2 csr_mstatus_i = 32'h80;
    @(negedge clk); #2;
    chk(hold_flag_o == 1'b0, "pending_masked", {63'd0, hold_flag_o}, 64'd0);

    csr_mepc_i = 32'h144;
    fire(32'h3020_0073, 32'h200, 8'h02, 1'b0, 32'h0, 32'h80, n);
    exp_w(n + 1, 12'h300, 32'h0000_0088);
    exp_j(n + 2, 32'h144);
    settle(1'b0);
    finish_seq(2, "prio_mret");

    fire(NOP, 32'h144, 8'h02, 1'b0, 32'h0, 32'h88, n);
    exp_w(n + 1, 12'h341, 32'h144);
    exp_w(n + 2, 12'h342, 32'h8000_000B);
    exp_w(n + 3, 12'h300, 32'h0000_0080);
    exp_j(n + 4, 32'h200);
    settle(1'b1);
    finish_seq(4, "ext_irq");

    // Reset during S_MCAUSE: no mstatus write may follow
    fire(32'h0000_0073, 32'h180, 8'h00, 1'b0, 32'h0, 32'h8, n);
    exp_w(n + 1, 12'h341, 32'h180);
    exp_w(n + 2, 12'h342, 32'h0000_000B);
    settle(1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk({hold_flag_o, we_o, int_assert_o, waddr_o, data_o, int_addr_o} == '0, "midseq_reset",
        {hold_flag_o, we_o, int_assert_o, waddr_o, data_o}, 64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    finish_seq(5, "midseq");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
